// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register with branch-redirect control: squashes the younger pipeline
// stages after a taken redirect and parks in a sticky fault state on illegal targets.
module pc_redirect_ctrl #(
    parameter int unsigned      PC_W      = 9,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    parameter int unsigned      FLUSH_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    output logic [PC_W-1:0] Cur_PC,
    output logic            Fetch_Valid,
    output logic            Flush_IFID,
    output logic            Flush_IDEX,
    output logic            Fault,
    output logic [1:0]      Fault_Code,
    output logic [15:0]     Redirect_Count
);

    typedef enum logic [1:0] {StRun, StSquash, StFault} state_e;

    localparam logic [2:0] FlushCyc = 3'(FLUSH_CYC);

    state_e          state_q, state_d;
    logic [2:0]      squash_q, squash_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [1:0]      fault_code_q, fault_code_d;
    logic [15:0]     redirect_cnt_q, redirect_cnt_d;

    logic [1:0]      cause;
    logic [PC_W-1:0] pc_inc;
    logic            fetch_valid;
    logic            flush;

    // bit0: misaligned target, bit1: target beyond the PC address space
    assign cause[0] = |BrPC[1:0];
    assign cause[1] = |(BrPC >> PC_W);
    assign pc_inc   = pc_q + PC_W'(4);

    always_comb begin
        state_d        = state_q;
        squash_d       = squash_q;
        pc_d           = pc_q;
        fault_d        = fault_q;
        fault_code_d   = fault_code_q;
        redirect_cnt_d = redirect_cnt_q;
        fetch_valid    = 1'b0;
        flush          = 1'b0;

        unique case (state_q)
            StRun: begin
                fetch_valid = 1'b1;
                if (PcSel) begin
                    // Redirect wins over Stall; gated by rst_n so reset never flushes
                    flush = rst_n;
                    if (cause == 2'b00) begin
                        pc_d     = BrPC[PC_W-1:0];
                        squash_d = FlushCyc;
                        state_d  = StSquash;
                        if (redirect_cnt_q != 16'hFFFF) begin
                            redirect_cnt_d = redirect_cnt_q + 16'd1;
                        end
                    end else begin
                        fault_d      = 1'b1;
                        fault_code_d = cause;
                        state_d      = StFault;
                    end
                end else if (!Stall) begin
                    pc_d = pc_inc;
                end
            end
            StSquash: begin
                // PcSel here comes from a wrong-path instruction and is dropped
                if (!Stall) begin
                    pc_d = pc_inc;
                end
                squash_d = squash_q - 3'd1;
                if (squash_d == 3'd0) begin
                    state_d = StRun;
                end
            end
            StFault: begin
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StRun;
            squash_q       <= 3'd0;
            pc_q           <= RESET_PC;
            fault_q        <= 1'b0;
            fault_code_q   <= 2'b00;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            squash_q       <= squash_d;
            pc_q           <= pc_d;
            fault_q        <= fault_d;
            fault_code_q   <= fault_code_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign Cur_PC         = pc_q;
    assign Fetch_Valid    = fetch_valid;
    assign Flush_IFID     = flush;
    assign Flush_IDEX     = flush;
    assign Fault          = fault_q;
    assign Fault_Code     = fault_code_q;
    assign Redirect_Count = redirect_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pc_redirect_ctrl;

    localparam int unsigned     PC_W      = 9;
    localparam logic [PC_W-1:0] RESET_PC  = '0;
    localparam int unsigned     FLUSH_CYC = 1;
    localparam int unsigned     VW        = PC_W + 22;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            stall  = 1'b0;
    logic            pc_sel = 1'b0;
    logic [31:0]     br_pc  = '0;
    logic [PC_W-1:0] cur_pc;
    logic            fetch_valid;
    logic            flush_ifid;
    logic            flush_idex;
    logic            fault;
    logic [1:0]      fault_code;
    logic [15:0]     redirect_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int unsigned m_pc;
    int          m_squash;
    bit          m_fault;
    logic [1:0]  m_code;
    int unsigned m_cnt;

    pc_redirect_ctrl #(
        .PC_W      (PC_W),
        .RESET_PC  (RESET_PC),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Stall          (stall),
        .PcSel          (pc_sel),
        .BrPC           (br_pc),
        .Cur_PC         (cur_pc),
        .Fetch_Valid    (fetch_valid),
        .Flush_IFID     (flush_ifid),
        .Flush_IDEX     (flush_idex),
        .Fault          (fault),
        .Fault_Code     (fault_code),
        .Redirect_Count (redirect_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [1:0] cause_of(input logic [31:0] t);
        return {((t >> PC_W) != 32'd0), (t[1:0] != 2'b00)};
    endfunction

    function automatic void model_reset();
        m_pc     = RESET_PC;
        m_squash = 0;
        m_fault  = 1'b0;
        m_code   = 2'b00;
        m_cnt    = 0;
    endfunction

    function automatic void model_edge();
        if (m_fault) return;
        if (m_squash > 0) begin
            if (!stall) m_pc = (m_pc + 4) % (1 << PC_W);
            m_squash--;
        end else if (pc_sel) begin
            if (cause_of(br_pc) == 2'b00) begin
                m_pc     = br_pc;
                m_squash = int'(FLUSH_CYC);
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_fault = 1'b1;
                m_code  = cause_of(br_pc);
            end
        end else if (!stall) begin
            m_pc = (m_pc + 4) % (1 << PC_W);
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic run;
        logic fl;
        run = !m_fault && (m_squash == 0);
        fl  = run && pc_sel && rst_n;
        return {PC_W'(m_pc), run, fl, fl, m_fault, m_code, 16'(m_cnt)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {cur_pc, fetch_valid, flush_ifid, flush_idex, fault, fault_code, redirect_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        stall  = 1'b0;
        pc_sel = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        pc_sel = 1'b1;
        br_pc  = 32'h40;
        #1;
        n_vec++;
        if (obs_vec() !== {RESET_PC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0}) begin
            n_err++;
            $display("FAIL reset_state: got %h required %h", obs_vec(),
                     {RESET_PC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0});
        end
        @(negedge clk);
        pc_sel = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_seq_fetch();
        for (int i = 0; i < 5; i++) begin
            stall  = 1'b0;
            pc_sel = 1'b0;
            #1;
            n_vec++;
            if (cur_pc !== PC_W'(i * 4) || fetch_valid !== 1'b1) begin
                n_err++;
                $display("FAIL seq_fetch[%0d]: got pc=%h fv=%b required pc=%h fv=1",
                         i, cur_pc, fetch_valid, PC_W'(i * 4));
            end
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL seq_fetch_model[%0d]: got %h required %h", i, obs_vec(), exp_vec());
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_redirect();
        pc_sel = 1'b1;
        br_pc  = 32'h40;
        #1;
        n_vec++;
        if (cur_pc !== 9'h010 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
            n_err++;
            $display("FAIL redirect_flush: got pc=%h flush=%b%b required pc=010 flush=11",
                     cur_pc, flush_ifid, flush_idex);
        end
        tick();
        pc_sel = 1'b0;
        #1;
        n_vec++;
        if (cur_pc !== 9'h040 || fetch_valid !== 1'b0 || flush_ifid !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_target: got pc=%h fv=%b fl=%b required pc=040 fv=0 fl=0",
                     cur_pc, fetch_valid, flush_ifid);
        end
        tick();
        #1;
        n_vec++;
        if (cur_pc !== 9'h044 || fetch_valid !== 1'b1 || redirect_count !== 16'd1) begin
            n_err++;
            $display("FAIL redirect_resume: got pc=%h fv=%b cnt=%0d required pc=044 fv=1 cnt=1",
                     cur_pc, fetch_valid, redirect_count);
        end
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL redirect_model: got %h required %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stall_vs_redirect();
        for (int i = 0; i < 3; i++) begin
            stall  = 1'b1;
            pc_sel = 1'b0;
            tick();
            #1;
            n_vec++;
            if (cur_pc !== 9'h044 || fetch_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got pc=%h fv=%b required pc=044 fv=1",
                         i, cur_pc, fetch_valid);
            end
        end
        pc_sel = 1'b1;
        br_pc  = 32'h80;
        tick();
        // wrong-path request during the squash cycle
        stall  = 1'b0;
        br_pc  = 32'h100;
        #1;
        n_vec++;
        if (cur_pc !== 9'h080 || flush_ifid !== 1'b0 || flush_idex !== 1'b0 || fetch_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_redirect: got pc=%h fl=%b%b fv=%b required pc=080 fl=00 fv=0",
                     cur_pc, flush_ifid, flush_idex, fetch_valid);
        end
        tick();
        pc_sel = 1'b0;
        #1;
        n_vec++;
        if (cur_pc !== 9'h084 || redirect_count !== 16'd2 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL squash_ignore: got pc=%h cnt=%0d fault=%b required pc=084 cnt=2 fault=0",
                     cur_pc, redirect_count, fault);
        end
    endtask

    task automatic test_faults();
        logic [31:0] tgt [3];
        logic [1:0]  code [3];
        tgt[0] = 32'h42;  code[0] = 2'b01;
        tgt[1] = 32'h200; code[1] = 2'b10;
        tgt[2] = 32'h202; code[2] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            pc_sel = 1'b1;
            br_pc  = tgt[k];
            #1;
            n_vec++;
            if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
                n_err++;
                $display("FAIL fault_flush[%0d]: got fl=%b%b required fl=11", k, flush_ifid, flush_idex);
            end
            tick();
            for (int c = 0; c < 3; c++) begin
                stall  = 1'($urandom_range(0, 1));
                pc_sel = 1'($urandom_range(0, 1));
                br_pc  = 32'h40;
                #1;
                n_vec++;
                if (fault !== 1'b1 || fault_code !== code[k] || cur_pc !== RESET_PC
                    || fetch_valid !== 1'b0 || flush_ifid !== 1'b0 || redirect_count !== 16'd0) begin
                    n_err++;
                    $display("FAIL fault_hold[%0d.%0d]: got f=%b code=%b pc=%h fv=%b fl=%b cnt=%0d required f=1 code=%b pc=%h fv=0 fl=0 cnt=0",
                             k, c, fault, fault_code, cur_pc, fetch_valid, flush_ifid,
                             redirect_count, code[k], RESET_PC);
                end
                tick();
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        pc_sel = 1'b1;
        br_pc  = 32'h1F8;
        tick();
        pc_sel = 1'b0;
        tick();
        #1;
        n_vec++;
        if (cur_pc !== 9'h1FC || fetch_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_pre: got pc=%h fv=%b required pc=1fc fv=1", cur_pc, fetch_valid);
        end
        tick();
        #1;
        n_vec++;
        if (cur_pc !== 9'h000) begin
            n_err++;
            $display("FAIL wrap: got pc=%h required pc=000", cur_pc);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] want [4];
        want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'hFFFF; want[3] = 16'hFFFF;
        do_reset();
        // Preload the counter near its limit instead of issuing 65k redirects
        force dut.redirect_cnt_q = 16'hFFFD;
        #1;
        release dut.redirect_cnt_q;
        m_cnt = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            pc_sel = 1'b1;
            br_pc  = 32'h40;
            tick();
            pc_sel = 1'b0;
            tick();
            #1;
            n_vec++;
            if (redirect_count !== want[i]) begin
                n_err++;
                $display("FAIL saturate[%0d]: got cnt=%h required cnt=%h", i, redirect_count, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid_squash();
        do_reset();
        br_pc  = 32'h40;
        pc_sel = 1'b1;
        tick();
        pc_sel = 1'b1;
        #1;
        n_vec++;
        if (fetch_valid !== 1'b0 || cur_pc !== 9'h040) begin
            n_err++;
            $display("FAIL mid_squash_pre: got fv=%b pc=%h required fv=0 pc=040", fetch_valid, cur_pc);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (cur_pc !== RESET_PC || fetch_valid !== 1'b1 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            n_err++;
            $display("FAIL mid_squash_reset: got pc=%h fv=%b fl=%b%b required pc=%h fv=1 fl=00",
                     cur_pc, fetch_valid, flush_ifid, flush_idex, RESET_PC);
        end
        @(posedge clk);
        @(negedge clk);
        pc_sel = 1'b0;
        rst_n  = 1'b1;
        #1;
        n_vec++;
        if (cur_pc !== RESET_PC || fetch_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_squash_release: got pc=%h fv=%b required pc=%h fv=1",
                     cur_pc, fetch_valid, RESET_PC);
        end
        tick();
        #1;
        n_vec++;
        if (cur_pc !== RESET_PC + PC_W'(4)) begin
            n_err++;
            $display("FAIL first_advance: got pc=%h required pc=%h", cur_pc, RESET_PC + PC_W'(4));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_fault && $urandom_range(0, 3) == 0) do_reset();
            stall  = ($urandom_range(0, 2) == 0);
            pc_sel = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) br_pc = $urandom;
            else br_pc = 32'($urandom_range(0, 127)) << 2;
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h required %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_seq_fetch();
        test_redirect();
        test_stall_vs_redirect();
        test_faults();
        test_wrap();
        test_saturation();
        test_reset_mid_squash();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter PC_W, default 9, is the PC register width in bits.
REQ-002 Parameter RESET_PC, default 0, is the PC value loaded on reset (PC_W bits).
REQ-003 Parameter FLUSH_CYC, default 1, sets the number of squash cycles after a redirect; legal range 1..7.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 Stall  in  1  hazard stall from hazard detection; holds the PC.
REQ-007 PcSel  in  1  redirect request from the branch unit in the EX stage.
REQ-008 BrPC  in  32  redirect target from the branch unit; sampled only when PcSel=1.
REQ-009 Cur_PC  out  PC_W  current fetch address, registered.
REQ-010 Fetch_Valid  out  1  the instruction fetched at Cur_PC is valid.
REQ-011 Flush_IFID  out  1  squash the IF/ID register this cycle.
REQ-012 Flush_IDEX  out  1  squash the ID/EX register this cycle.
REQ-013 Fault  out  1  sticky illegal-target flag, registered.
REQ-014 Fault_Code  out  2  fault cause: bit0 = misaligned (BrPC[1:0]!=0); bit1 = out of range (BrPC[31:PC_W]!=0).
REQ-015 Redirect_Count  out  16  count of accepted redirects, registered.

Function
REQ-016 The FSM SHALL have three states: RUN, SQUASH and FAULT.
REQ-017 A redirect is accepted in cycle N when state=RUN, PcSel=1 and BrPC is legal (Fault_Code cause bits both 0).
REQ-018 In RUN with an accepted redirect:
  - Cur_PC = BrPC[PC_W-1:0] at N+1
  - Flush_IFID = Flush_IDEX = 1 combinationally in cycle N
  - state -> SQUASH with the squash counter loaded to FLUSH_CYC
  - Redirect_Count increments
REQ-019 A redirect SHALL take priority over Stall; Stall is ignored in the cycle a redirect is accepted.
REQ-020 In RUN with PcSel=0 and Stall=1, Cur_PC SHALL hold.
REQ-021 In RUN with PcSel=0 and Stall=0, Cur_PC SHALL advance by 4 modulo 2^PC_W (wrap-around: 0x1FC -> 0x000 for PC_W=9).
REQ-022 In SQUASH:
  - Fetch_Valid = 0
  - Cur_PC advances by 4 per cycle when Stall=0 and holds when Stall=1
  - the squash counter decrements every cycle regardless of Stall
  - state -> RUN when the counter reaches 0
REQ-023 PcSel SHALL be ignored in SQUASH (wrong-path request): no flush, no count, no fault.
REQ-024 In RUN with PcSel=1 and an illegal BrPC:
  - Fault = 1 and Fault_Code = cause bits, at N+1
  - Flush_IFID = Flush_IDEX = 1 in cycle N
  - Cur_PC holds
  - state -> FAULT
  - Redirect_Count does not change
REQ-025 In FAULT:
  - Fetch_Valid = 0
  - Cur_PC, Fault and Fault_Code hold
  - all inputs are ignored
  - the block exits FAULT only on reset
REQ-026 Fetch_Valid SHALL be 1 only in RUN.
REQ-027 Flush_IFID and Flush_IDEX SHALL be 0 in every cycle other than the cases in REQ-018 and REQ-024.
REQ-028 Redirect_Count SHALL saturate at 0xFFFF.

Reset
REQ-029 While rst_n=0, regardless of clk:
  - Cur_PC = RESET_PC
  - state = RUN, squash counter = 0
  - Fault = 0, Fault_Code = 0, Redirect_Count = 0
REQ-030 While rst_n=0, the combinational outputs SHALL be Fetch_Valid = 1, Flush_IFID = 0 and Flush_IDEX = 0.
REQ-031 Reset asserted during SQUASH or FAULT SHALL abort that state immediately, with no residual flush.
REQ-032 The first PC advance SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-033 Sequential fetch: reset, Stall=0, PcSel=0 for 4 edges -> Cur_PC = 0x000, 0x004, 0x008, 0x00C, 0x010; Fetch_Valid=1 throughout.
REQ-034 Taken redirect: at Cur_PC=0x010, PcSel=1 and BrPC=0x40 for one cycle -> flushes=1 that cycle; next cycle Cur_PC=0x040, Fetch_Valid=0; the cycle after, Cur_PC=0x044, Fetch_Valid=1; Redirect_Count=1.
REQ-035 Stall versus redirect: Stall=1 with PcSel=0 for 3 cycles -> Cur_PC held; then Stall=1 with PcSel=1 and BrPC=0x80 -> Cur_PC=0x080 next cycle; a PcSel pulse during SQUASH is ignored.
REQ-036 Faults:
  - BrPC=0x42 -> Fault=1, Fault_Code=01, Cur_PC held, Fetch_Valid=0 until reset
  - after reset, BrPC=0x200 -> Fault_Code=10
  - after reset, BrPC=0x202 -> Fault_Code=11
REQ-037 Wrap and saturation:
  - Cur_PC=0x1FC with no stall -> 0x000
  - 65,536 accepted redirects -> Redirect_Count=0xFFFF and holds
REQ-038 Reset mid-squash: assert rst_n=0 in SQUASH between clock edges -> Cur_PC=RESET_PC immediately; Fetch_Valid=1 and state RUN after release.
